// File: rtl/ex_pkg.sv
// Shared encodings for the MIPS execute stage: ALU op codes, forward selects and
// the multiplier FSM state type.
package ex_pkg;

    typedef enum logic [3:0] {
        AluAnd   = 4'h0,
        AluOr    = 4'h1,
        AluAdd   = 4'h2,
        AluSll   = 4'h3,
        AluSrl   = 4'h4,
        AluSra   = 4'h5,
        AluSub   = 4'h6,
        AluSlt   = 4'h7,
        AluMfhi  = 4'h8,
        AluMflo  = 4'h9,
        AluMult  = 4'hA,
        AluMultu = 4'hB,
        AluNor   = 4'hC
    } alu_op_e;

    localparam logic [1:0] FwdId  = 2'b00;
    localparam logic [1:0] FwdWb  = 2'b01;
    localparam logic [1:0] FwdMem = 2'b10;

    typedef enum logic [1:0] {
        MulIdle,
        MulBusy,
        MulDone
    } mul_state_e;

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX inputs and EX/MEM outputs of the execute stage; master drives the
// upstream side, slave is the execute stage itself.
interface ex_stage_if #(
    parameter int unsigned WIDTH = 32
);
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic [WIDTH-1:0] imm_ext;
    logic [4:0]       shamt;
    logic [3:0]       alu_ctrl;
    logic             alu_src;
    logic             reg_dst;
    logic [4:0]       rt_ex;
    logic [4:0]       rd_ex;
    logic             regWrite_ex;
    logic             memRead_ex;
    logic             memWrite_ex;
    logic             memToReg_ex;
    logic [1:0]       forwardA;
    logic [1:0]       forwardB;
    logic [WIDTH-1:0] wb_data;

    logic [WIDTH-1:0] alu_result_mem;
    logic [WIDTH-1:0] store_data_mem;
    logic [4:0]       rd_mem;
    logic             regWrite_mem;
    logic             memRead_mem;
    logic             memWrite_mem;
    logic             memToReg_mem;
    logic             zero_mem;
    logic             stall_ex;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output rs_data, rt_data, imm_ext, shamt, alu_ctrl, alu_src, reg_dst, rt_ex, rd_ex,
               regWrite_ex, memRead_ex, memWrite_ex, memToReg_ex, forwardA, forwardB, wb_data,
        input  alu_result_mem, store_data_mem, rd_mem, regWrite_mem, memRead_mem,
               memWrite_mem, memToReg_mem, zero_mem, stall_ex, hi, lo
    );

    modport slave (
        input  rs_data, rt_data, imm_ext, shamt, alu_ctrl, alu_src, reg_dst, rt_ex, rd_ex,
               regWrite_ex, memRead_ex, memWrite_ex, memToReg_ex, forwardA, forwardB, wb_data,
        output alu_result_mem, store_data_mem, rd_mem, regWrite_mem, memRead_mem,
               memWrite_mem, memToReg_mem, zero_mem, stall_ex, hi, lo
    );

endinterface

// File: rtl/mult_seq.sv
// Sequential shift-add multiplier: one add/shift step per cycle on magnitudes,
// sign restored on the 64-bit product.
module mult_seq
    import ex_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MUL_CYCLES = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_start,
    input  logic               i_signed,
    input  logic [WIDTH-1:0]   i_op_a,
    input  logic [WIDTH-1:0]   i_op_b,
    output logic               o_busy,
    output logic               o_done,
    output logic [2*WIDTH-1:0] o_product
);
    localparam int unsigned    CntW    = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(MUL_CYCLES - 1);

    mul_state_e         r_state;
    mul_state_e         w_state_d;
    logic [CntW-1:0]    r_cnt;
    logic [WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0] r_prod;
    logic               r_neg;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH-1:0]   w_addend;
    logic [WIDTH:0]     w_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= MulIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        o_busy    = 1'b1;
        o_done    = 1'b0;
        case (r_state)
            MulIdle: begin
                o_busy = 1'b0;
                if (i_start) w_state_d = MulBusy;
            end
            MulBusy: begin
                if (r_cnt == LastCnt) w_state_d = MulDone;
            end
            MulDone: begin
                o_done    = 1'b1;
                w_state_d = MulIdle;
            end
            default: w_state_d = MulIdle;
        endcase
    end

    assign w_abs_a  = (i_signed && i_op_a[WIDTH-1]) ? -i_op_a : i_op_a;
    assign w_abs_b  = (i_signed && i_op_b[WIDTH-1]) ? -i_op_b : i_op_b;
    // Upper half accumulates; the multiplier drains out of the lower half.
    assign w_addend = r_prod[0] ? r_mcand : '0;
    assign w_sum    = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_mcand <= '0;
            r_prod  <= '0;
            r_neg   <= 1'b0;
        end else if (r_state == MulIdle && i_start) begin
            r_cnt   <= '0;
            r_mcand <= w_abs_a;
            r_prod  <= {{WIDTH{1'b0}}, w_abs_b};
            r_neg   <= i_signed && (i_op_a[WIDTH-1] ^ i_op_b[WIDTH-1]);
        end else if (r_state == MulBusy) begin
            r_cnt   <= r_cnt + 1'b1;
            r_prod  <= {w_sum, r_prod[WIDTH-1:1]};
        end
    end

    assign o_product = r_neg ? -r_prod : r_prod;

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: operand forwarding, single-cycle ALU, EX/MEM register and
// HI/LO owned by the sequential multiplier.
module ex_stage
    import ex_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MUL_CYCLES = 32
) (
    input logic       clk,
    input logic       rst_n,
    ex_stage_if.slave bus
);
    logic [WIDTH-1:0]   w_op_a;
    logic [WIDTH-1:0]   w_fwd_b;
    logic [WIDTH-1:0]   w_op_b;
    logic [WIDTH-1:0]   w_alu_res;
    logic [2*WIDTH-1:0] w_product;
    logic               w_is_mul;
    logic               w_mul_start;
    logic               w_mul_signed;
    logic               w_mul_busy;
    logic               w_mul_done;
    logic               w_stall;

    logic [WIDTH-1:0]   r_result;
    logic [WIDTH-1:0]   r_store;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [4:0]         r_rd;
    logic               r_reg_write;
    logic               r_mem_read;
    logic               r_mem_write;
    logic               r_mem_to_reg;
    logic               r_zero;

    always_comb begin
        case (bus.forwardA)
            FwdWb:   w_op_a = bus.wb_data;
            FwdMem:  w_op_a = r_result;
            default: w_op_a = bus.rs_data;
        endcase
        case (bus.forwardB)
            FwdWb:   w_fwd_b = bus.wb_data;
            FwdMem:  w_fwd_b = r_result;
            default: w_fwd_b = bus.rt_data;
        endcase
        w_op_b = bus.alu_src ? bus.imm_ext : w_fwd_b;
    end

    always_comb begin
        w_alu_res = '0;
        case (bus.alu_ctrl)
            AluAnd:  w_alu_res = w_op_a & w_op_b;
            AluOr:   w_alu_res = w_op_a | w_op_b;
            AluNor:  w_alu_res = ~(w_op_a | w_op_b);
            AluAdd:  w_alu_res = w_op_a + w_op_b;
            AluSub:  w_alu_res = w_op_a - w_op_b;
            AluSlt:  w_alu_res = {{(WIDTH-1){1'b0}}, $signed(w_op_a) < $signed(w_op_b)};
            AluSll:  w_alu_res = w_fwd_b << bus.shamt;
            AluSrl:  w_alu_res = w_fwd_b >> bus.shamt;
            AluSra:  w_alu_res = $unsigned($signed(w_fwd_b) >>> bus.shamt);
            AluMfhi: w_alu_res = r_hi;
            AluMflo: w_alu_res = r_lo;
            default: w_alu_res = '0;
        endcase
    end

    assign w_is_mul     = (bus.alu_ctrl == AluMult) || (bus.alu_ctrl == AluMultu);
    assign w_mul_signed = (bus.alu_ctrl == AluMult);
    assign w_mul_start  = w_is_mul && !w_mul_busy;
    // Any instruction seen while the multiplier is active (or issuing) waits.
    assign w_stall      = w_mul_busy || w_is_mul;

    mult_seq #(
        .WIDTH      (WIDTH),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mult_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_start   (w_mul_start),
        .i_signed  (w_mul_signed),
        .i_op_a    (w_op_a),
        .i_op_b    (w_op_b),
        .o_busy    (w_mul_busy),
        .o_done    (w_mul_done),
        .o_product (w_product)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result     <= '0;
            r_store      <= '0;
            r_rd         <= '0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_zero       <= 1'b0;
        end else if (w_stall) begin
            // Bubble: data fields hold, only the control bits are cleared.
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
        end else begin
            r_result     <= w_alu_res;
            r_store      <= w_fwd_b;
            r_rd         <= bus.reg_dst ? bus.rd_ex : bus.rt_ex;
            r_reg_write  <= bus.regWrite_ex;
            r_mem_read   <= bus.memRead_ex;
            r_mem_write  <= bus.memWrite_ex;
            r_mem_to_reg <= bus.memToReg_ex;
            r_zero       <= (w_alu_res == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_mul_done) begin
            r_hi <= w_product[2*WIDTH-1:WIDTH];
            r_lo <= w_product[WIDTH-1:0];
        end
    end

    assign bus.alu_result_mem = r_result;
    assign bus.store_data_mem = r_store;
    assign bus.rd_mem         = r_rd;
    assign bus.regWrite_mem   = r_reg_write;
    assign bus.memRead_mem    = r_mem_read;
    assign bus.memWrite_mem   = r_mem_write;
    assign bus.memToReg_mem   = r_mem_to_reg;
    assign bus.zero_mem       = r_zero;
    assign bus.stall_ex       = w_stall;
    assign bus.hi             = r_hi;
    assign bus.lo             = r_lo;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed vector table, multiplier sequences,
// randomized ALU traffic against an arithmetic reference model.
module tb_ex_stage;
    import ex_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic [31:0] m_res;

    ex_stage_if #(.WIDTH(32)) bus ();

    ex_stage #(
        .WIDTH      (32),
        .MUL_CYCLES (32)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] imm;
        logic [4:0]  sh;
        logic        src;
        logic        dst;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [31:0] wb;
        logic [3:0]  ctrl;
        logic [31:0] exp_res;
        logic [31:0] exp_store;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    task automatic set_nop();
        bus.rs_data     = '0;
        bus.rt_data     = '0;
        bus.imm_ext     = '0;
        bus.shamt       = '0;
        bus.alu_ctrl    = AluAnd;
        bus.alu_src     = 1'b0;
        bus.reg_dst     = 1'b0;
        bus.rt_ex       = 5'd2;
        bus.rd_ex       = 5'd9;
        bus.regWrite_ex = 1'b0;
        bus.memRead_ex  = 1'b0;
        bus.memWrite_ex = 1'b0;
        bus.memToReg_ex = 1'b0;
        bus.forwardA    = FwdId;
        bus.forwardB    = FwdId;
        bus.wb_data     = '0;
    endtask

    function automatic logic [3:0] ctrl_mem();
        return {bus.regWrite_mem, bus.memRead_mem, bus.memWrite_mem, bus.memToReg_mem};
    endfunction

    // Reference ALU from plain integer arithmetic.
    function automatic logic [31:0] model_alu(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [31:0] fb,
                                              input logic [4:0] sh);
        longint sb;
        longint p;
        longint q;
        logic [63:0] wide;
        case (op)
            4'h0: return a & b;
            4'h1: return a | b;
            4'h2: return a + b;
            4'h6: return a - b;
            4'h7: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'h3: begin
                wide = {32'b0, fb} * (64'd1 << sh);
                return wide[31:0];
            end
            4'h4: return fb / (32'd1 << sh);
            4'h5: begin
                sb = longint'(int'(fb));
                p  = longint'(1) << sh;
                if (sb >= 0) q = sb / p;
                else         q = -((-sb + p - 1) / p);
                return q[31:0];
            end
            4'h8: return m_hi;
            4'h9: return m_lo;
            4'hC: return ~(a | b);
            default: return 32'd0;
        endcase
    endfunction

    task automatic do_mult(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] fop);
        logic [63:0] exp_prod;
        int cyc;
        int bub;
        if (sgn) exp_prod = longint'(int'(a)) * longint'(int'(b));
        else     exp_prod = {32'b0, a} * {32'b0, b};
        set_nop();
        bus.alu_ctrl    = sgn ? AluMult : AluMultu;
        bus.rs_data     = a;
        bus.rt_data     = b;
        bus.regWrite_ex = 1'b1;
        #1;
        check("mul_issue_stall", 64'(bus.stall_ex), 64'd1);
        cyc = 0;
        bub = 0;
        while (bus.stall_ex && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            if (ctrl_mem() != 4'b0000) bub++;
            if (cyc == 1) begin
                set_nop();
                bus.alu_ctrl    = fop;
                bus.reg_dst     = 1'b1;
                bus.regWrite_ex = 1'b1;
                bus.rs_data     = $urandom;
                bus.rt_data     = $urandom;
            end
        end
        check("mul_stall_cycles", 64'(cyc), 64'd34);
        check("mul_bubbles", 64'(bub), 64'd0);
        check("mul_hi", 64'(bus.hi), 64'(exp_prod[63:32]));
        check("mul_lo", 64'(bus.lo), 64'(exp_prod[31:0]));
        m_hi = exp_prod[63:32];
        m_lo = exp_prod[31:0];
        @(posedge clk);
        #1;
        m_res = (fop == AluMfhi) ? m_hi : m_lo;
        check("mf_after_done", 64'(bus.alu_result_mem), 64'(m_res));
        check("mf_after_done_rw", 64'(bus.regWrite_mem), 64'd1);
        check("mf_after_done_rd", 64'(bus.rd_mem), 64'd9);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  ops[11];
        logic [31:0] a;
        logic [31:0] fb;
        logic [31:0] b;
        logic [31:0] exp_r;
        logic [31:0] ra;
        logic [31:0] rb;
        clk      = 1'b0;
        rst_n    = 1'b0;
        n_checks = 0;
        n_fail   = 0;
        m_hi     = '0;
        m_lo     = '0;
        m_res    = '0;
        set_nop();

        //          op      rs            rt            imm     sh  src dst fa fb wb            ctrl     res           store
        vecs[0]  = '{AluAdd,  32'd5,        32'd7,        32'h0,  5'd0, 0, 1, 0, 0, 32'h0,        4'b1000, 32'd12,       32'd7};
        vecs[1]  = '{AluAdd,  32'h10,       32'h0,        32'h0,  5'd0, 0, 0, 0, 0, 32'h0,        4'b1001, 32'h10,       32'h0};
        vecs[2]  = '{AluSub,  32'hDEAD,     32'hBEEF,     32'h0,  5'd0, 0, 1, 2, 1, 32'd3,        4'b1000, 32'h0D,       32'd3};
        vecs[3]  = '{AluSlt,  32'hFFFFFFFF, 32'd1,        32'h0,  5'd0, 0, 1, 0, 0, 32'h0,        4'b1000, 32'd1,        32'd1};
        vecs[4]  = '{AluSra,  32'h1234,     32'h80000000, 32'h0,  5'd4, 0, 1, 0, 0, 32'h0,        4'b1000, 32'hF8000000, 32'h80000000};
        vecs[5]  = '{AluSub,  32'd9,        32'd9,        32'h0,  5'd0, 0, 0, 0, 0, 32'h0,        4'b1000, 32'd0,        32'd9};
        vecs[6]  = '{AluOr,   32'hF0,       32'hFFFF,     32'h0F, 5'd0, 1, 0, 0, 0, 32'h0,        4'b0010, 32'hFF,       32'hFFFF};
        vecs[7]  = '{AluNor,  32'h0,        32'h0,        32'h0,  5'd0, 0, 1, 0, 0, 32'h0,        4'b1000, 32'hFFFFFFFF, 32'h0};
        vecs[8]  = '{AluAnd,  32'hFF00,     32'h0FF0,     32'h0,  5'd0, 0, 1, 3, 3, 32'hFFFFFFFF, 4'b1000, 32'h0F00,     32'h0FF0};
        vecs[9]  = '{AluSll,  32'h0,        32'd1,        32'h0,  5'd31,0, 1, 0, 0, 32'h0,        4'b0100, 32'h80000000, 32'd1};
        vecs[10] = '{AluSrl,  32'h0,        32'h0,        32'h0,  5'd31,0, 0, 0, 2, 32'h0,        4'b1000, 32'd1,        32'h80000000};
        vecs[11] = '{AluMflo, 32'h5,        32'h6,        32'h0,  5'd0, 0, 1, 0, 0, 32'h0,        4'b1000, 32'd0,        32'h6};

        #12;
        check("rst_result", 64'(bus.alu_result_mem), 64'd0);
        check("rst_rd", 64'(bus.rd_mem), 64'd0);
        check("rst_ctrl", 64'(ctrl_mem()), 64'd0);
        check("rst_zero", 64'(bus.zero_mem), 64'd0);
        check("rst_stall", 64'(bus.stall_ex), 64'd0);
        check("rst_hilo", {bus.hi, bus.lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            set_nop();
            bus.alu_ctrl = vecs[i].op;
            bus.rs_data  = vecs[i].rs;
            bus.rt_data  = vecs[i].rt;
            bus.imm_ext  = vecs[i].imm;
            bus.shamt    = vecs[i].sh;
            bus.alu_src  = vecs[i].src;
            bus.reg_dst  = vecs[i].dst;
            bus.forwardA = vecs[i].fa;
            bus.forwardB = vecs[i].fb;
            bus.wb_data  = vecs[i].wb;
            {bus.regWrite_ex, bus.memRead_ex, bus.memWrite_ex, bus.memToReg_ex} = vecs[i].ctrl;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_result", i), 64'(bus.alu_result_mem), 64'(vecs[i].exp_res));
            check($sformatf("vec%0d_zero", i), 64'(bus.zero_mem), 64'(vecs[i].exp_res == 0));
            check($sformatf("vec%0d_rd", i), 64'(bus.rd_mem), vecs[i].dst ? 64'd9 : 64'd2);
            check($sformatf("vec%0d_ctrl", i), 64'(ctrl_mem()), 64'(vecs[i].ctrl));
            check($sformatf("vec%0d_store", i), 64'(bus.store_data_mem), 64'(vecs[i].exp_store));
            check($sformatf("vec%0d_stall", i), 64'(bus.stall_ex), 64'd0);
        end
        m_res = vecs[11].exp_res;

        do_mult(1'b1, 32'hFFFFFFFD, 32'd7, AluMfhi);
        do_mult(1'b0, 32'hFFFFFFFF, 32'd2, AluMflo);
        check("multu_hi_is_1", 64'(bus.hi), 64'd1);
        do_mult(1'b1, 32'h80000000, 32'h80000000, AluMfhi);
        for (int i = 0; i < 5; i++) begin
            do_mult(1'($urandom_range(0, 1)), $urandom, $urandom,
                    ($urandom_range(0, 1) != 0) ? AluMfhi : AluMflo);
        end

        ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hC};
        for (int i = 0; i < 40; i++) begin
            set_nop();
            bus.alu_ctrl    = ops[$urandom_range(0, 10)];
            bus.rs_data     = $urandom;
            bus.rt_data     = ($urandom_range(0, 3) == 0) ? bus.rs_data : $urandom;
            bus.imm_ext     = $urandom;
            bus.shamt       = 5'($urandom_range(0, 31));
            bus.alu_src     = 1'($urandom_range(0, 1));
            bus.reg_dst     = 1'($urandom_range(0, 1));
            bus.rt_ex       = 5'($urandom_range(0, 31));
            bus.rd_ex       = 5'($urandom_range(0, 31));
            bus.forwardA    = 2'($urandom_range(0, 3));
            bus.forwardB    = 2'($urandom_range(0, 3));
            bus.wb_data     = $urandom;
            {bus.regWrite_ex, bus.memRead_ex, bus.memWrite_ex, bus.memToReg_ex} =
                4'($urandom_range(0, 15));
            a  = (bus.forwardA == 2'd1) ? bus.wb_data : (bus.forwardA == 2'd2) ? m_res
                                                                              : bus.rs_data;
            fb = (bus.forwardB == 2'd1) ? bus.wb_data : (bus.forwardB == 2'd2) ? m_res
                                                                              : bus.rt_data;
            b  = bus.alu_src ? bus.imm_ext : fb;
            exp_r = model_alu(bus.alu_ctrl, a, b, fb, bus.shamt);
            ra = {27'b0, bus.reg_dst ? bus.rd_ex : bus.rt_ex};
            rb = {28'b0, bus.regWrite_ex, bus.memRead_ex, bus.memWrite_ex, bus.memToReg_ex};
            @(posedge clk);
            #1;
            check($sformatf("rnd%0d_result", i), 64'(bus.alu_result_mem), 64'(exp_r));
            check($sformatf("rnd%0d_zero", i), 64'(bus.zero_mem), 64'(exp_r == 0));
            check($sformatf("rnd%0d_rd", i), 64'(bus.rd_mem), 64'(ra));
            check($sformatf("rnd%0d_ctrl", i), 64'(ctrl_mem()), 64'(rb));
            check($sformatf("rnd%0d_store", i), 64'(bus.store_data_mem), 64'(fb));
            m_res = exp_r;
        end

        // Reset in the middle of a multiply, with MFLO waiting behind it.
        set_nop();
        bus.alu_ctrl = AluMult;
        bus.rs_data  = 32'h1234;
        bus.rt_data  = 32'h55;
        @(posedge clk);
        #1;
        set_nop();
        bus.alu_ctrl    = AluMflo;
        bus.reg_dst     = 1'b1;
        bus.regWrite_ex = 1'b1;
        repeat (10) @(posedge clk);
        #3;
        check("busy_before_rst", 64'(bus.stall_ex), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_stall", 64'(bus.stall_ex), 64'd0);
        check("rst_mid_hilo", {bus.hi, bus.lo}, 64'd0);
        check("rst_mid_result", 64'(bus.alu_result_mem), 64'd0);
        check("rst_mid_ctrl", 64'(ctrl_mem()), 64'd0);
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_mflo", 64'(bus.alu_result_mem), 64'(m_lo));
        check("post_rst_zero", 64'(bus.zero_mem), 64'd1);
        check("post_rst_rw", 64'(bus.regWrite_mem), 64'd1);
        check("post_rst_stall", 64'(bus.stall_ex), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline. It sits downstream of ForwardingUnit and consumes forwardA/forwardB.
- Selects ALU operands from the ID/EX values, the EX/MEM result or the WB data.
- Runs the single-cycle ALU and a multi-cycle 32-step shift-add multiplier that owns HI/LO.
- Registers results into the EX/MEM pipeline register.
- Drives stall_ex upstream while the multiplier is busy.

Parameters:
- WIDTH, 32, datapath width.
- MUL_CYCLES, 32, multiplier iteration count; must equal WIDTH.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- rs_data  in  WIDTH  ID/EX rs register value.
- rt_data  in  WIDTH  ID/EX rt register value.
- imm_ext  in  WIDTH  ID/EX sign-extended immediate.
- shamt  in  5  shift amount.
- alu_ctrl  in  4  operation code (see package).
- alu_src  in  1  1 = operand B is imm_ext.
- reg_dst  in  1  1 = destination is rd_ex, 0 = destination is rt_ex.
- rt_ex  in  5  ID/EX rt index.
- rd_ex  in  5  ID/EX rd index.
- regWrite_ex, memRead_ex, memWrite_ex, memToReg_ex  in  1 each  ID/EX control bits.
- forwardA, forwardB  in  2  00 = ID/EX value, 01 = wb_data, 10 = alu_result_mem, 11 = treated as 00.
- wb_data  in  WIDTH  WB-stage write data.
- alu_result_mem  out  WIDTH  EX/MEM result; also used as the forward source.
- store_data_mem  out  WIDTH  forwarded operand B before the alu_src mux.
- rd_mem  out  5  EX/MEM destination index.
- regWrite_mem, memRead_mem, memWrite_mem, memToReg_mem  out  1 each  EX/MEM control bits.
- zero_mem  out  1  registered (ALU result == 0).
- stall_ex  out  1  hold IF/ID/ID-EX; combinational.
- hi, lo  out  WIDTH  multiplier result registers.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All EX/MEM outputs, hi and lo go to 0.
  - FSM goes to IDLE; stall_ex = 0.
  - Reset mid-multiply abandons the operation; HI/LO = 0.
- Operand select:
  - opA = mux(forwardA).
  - fwdB = mux(forwardB).
  - opB = alu_src ? imm_ext : fwdB.
- ALU operations, each 1 cycle, registered on the next rising clk:
  - AND, OR, NOR.
  - ADD/SUB: wrap-around, no overflow trap.
  - SLT: signed compare, result 0 or 1.
  - SLL/SRL/SRA: shift fwdB by shamt.
  - MFHI/MFLO: return hi / lo.
- Destination and writeback:
  - rd_mem = reg_dst ? rd_ex : rt_ex.
  - MULT and MULTU never set regWrite_mem, even if regWrite_ex is set.
- Multiplier FSM: IDLE, BUSY, DONE.
  - IDLE -> BUSY when alu_ctrl is MULT/MULTU and regs are not held by stall. Latch |opA| and |opB| (MULT) or the raw values (MULTU), record the result sign, counter = 0.
  - The issuing cycle itself is registered into EX/MEM as a bubble (all control bits 0).
  - BUSY: one shift-add step per cycle; after MUL_CYCLES steps go to DONE.
  - DONE: write {hi,lo} (negated 64-bit product if the sign flag is set), go to IDLE. Total 34 cycles from the issue edge to HI/LO valid.
- stall_ex:
  - High from the issue cycle through DONE inclusive.
  - While stalled, the ID/EX inputs are held by upstream.
  - Each stalled cycle writes a bubble into EX/MEM.
- Interlocks:
  - MFHI/MFLO or a new MULT presented while busy waits; it executes in the cycle after DONE.
  - The cycle after DONE, MFHI returns the new HI.
- While the multiplier is idle, stall_ex is 0 and ALU ops flow back-to-back with no bubbles.
- Forward source: alu_result_mem feeds back the same-cycle registered value; there is no internal bypass.

Decomposition:
- Package ex_pkg holds:
  - ALU codes: AND=0, OR=1, ADD=2, SLL=3, SRL=4, SRA=5, SUB=6, SLT=7, MFHI=8, MFLO=9, MULT=A, MULTU=B, NOR=C.
  - FWD_ID=00, FWD_WB=01, FWD_MEM=10.
  - Multiplier state enum.
- One sub-module, mult_seq: FSM, counter, shift-add datapath, sign fix-up; ports start/busy/done/product. ALU stays inline.

Test Plan:
- ADD, rs_data=5, rt_data=7, forward 00/00 -> next cycle alu_result_mem=12, zero_mem=0, rd_mem follows reg_dst.
- forwardA=10 with alu_result_mem=0x10, forwardB=01 with wb_data=3, SUB -> result 0x0D.
- SLT -1 vs 1 -> result 1; SRA on 0x80000000, shamt 4 -> 0xF8000000.
- MULT -3 x 7 -> stall_ex high 34 cycles, EX/MEM bubbles, then {hi,lo}=0xFFFFFFFF_FFFFFFEB.
- MULTU 0xFFFFFFFF x 2 -> hi=1, lo=0xFFFFFFFE.
- MFLO issued during BUSY -> held; it returns the new lo in the cycle after DONE.
- rst_n pulsed low mid-BUSY -> immediate idle, stall_ex=0, hi=lo=0.
